// File: rtl/regfile_writeback.sv
// Writeback arbiter between an ALU result port and a load (LSU) result port,
// with a one-entry LSU holding buffer, a busy scoreboard and same-cycle
// operand forwarding.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   issue_valid_i, issue_rd_i          instruction issued that will write rd
//   alu_valid_i/rd_i/data_i, alu_ready_o   ALU result handshake
//   lsu_valid_i/rd_i/data_i, lsu_ready_o   load result handshake into buffer
//   rd_addr_o, rd_data_o, rd_we_o      register file write port
//   rs_addr_a_i, rs_addr_b_i           operand addresses being read
//   rs_a_busy_o, rs_b_busy_o           operand pending and not forwardable
//   fwd_a/b_valid_o, fwd_a/b_data_o    same-cycle writeback forward
module regfile_writeback #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_ready_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_we_o,
  input  logic [4:0]  rs_addr_a_i,
  input  logic [4:0]  rs_addr_b_i,
  output logic        rs_a_busy_o,
  output logic        rs_b_busy_o,
  output logic        fwd_a_valid_o,
  output logic [31:0] fwd_a_data_o,
  output logic        fwd_b_valid_o,
  output logic [31:0] fwd_b_data_o
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic        buf_full_q, buf_full_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] busy_q, busy_d;
  logic [3:0]  starve_q, starve_d;

  logic starved;
  logic sel_alu;
  logic sel_buf;

  // A starved buffer beats the ALU; otherwise the ALU has priority.
  assign starved = buf_full_q && (starve_q == StarveMax);
  assign sel_alu = alu_valid_i && !starved;
  assign sel_buf = buf_full_q && (starved || !alu_valid_i);

  assign alu_ready_o = !starved;
  assign lsu_ready_o = !buf_full_q;

  always_comb begin
    rd_addr_o = 5'd0;
    rd_data_o = 32'd0;
    if (sel_buf) begin
      rd_addr_o = buf_rd_q;
      rd_data_o = buf_data_q;
    end else if (sel_alu) begin
      rd_addr_o = alu_rd_i;
      rd_data_o = alu_data_i;
    end
  end

  // x0 results are consumed but never written.
  assign rd_we_o = (sel_alu || sel_buf) && (rd_addr_o != 5'd0);

  always_comb begin
    fwd_a_valid_o = rd_we_o && (rd_addr_o == rs_addr_a_i) && (rs_addr_a_i != 5'd0);
    fwd_b_valid_o = rd_we_o && (rd_addr_o == rs_addr_b_i) && (rs_addr_b_i != 5'd0);
    fwd_a_data_o  = fwd_a_valid_o ? rd_data_o : 32'd0;
    fwd_b_data_o  = fwd_b_valid_o ? rd_data_o : 32'd0;
    rs_a_busy_o   = busy_q[rs_addr_a_i] && !fwd_a_valid_o;
    rs_b_busy_o   = busy_q[rs_addr_b_i] && !fwd_b_valid_o;
  end

  always_comb begin
    buf_full_d = buf_full_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    // Drain and load are exclusive: lsu_ready_o is low whenever the buffer is full.
    if (sel_buf) begin
      buf_full_d = 1'b0;
    end else if (lsu_valid_i && lsu_ready_o) begin
      buf_full_d = 1'b1;
      buf_rd_d   = lsu_rd_i;
      buf_data_d = lsu_data_i;
    end
  end

  always_comb begin
    starve_d = 4'd0;
    if (buf_full_q && !sel_buf) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
    end
  end

  // Clear first so that a same-cycle issue to the written register wins.
  always_comb begin
    busy_d = busy_q;
    if (rd_we_o) begin
      busy_d[rd_addr_o] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_i != 5'd0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_full_q <= 1'b0;
      busy_q     <= 32'd0;
      starve_q   <= 4'd0;
    end else begin
      buf_full_q <= buf_full_d;
      busy_q     <= busy_d;
      starve_q   <= starve_d;
    end
  end

  // Payload needs no reset; it is qualified by buf_full_q.
  always_ff @(posedge clk_i) begin
    buf_rd_q   <= buf_rd_d;
    buf_data_q <= buf_data_d;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  localparam int Limit = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        alu_ready_o;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic        lsu_ready_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_we_o;
  logic [4:0]  rs_addr_a_i;
  logic [4:0]  rs_addr_b_i;
  logic        rs_a_busy_o;
  logic        rs_b_busy_o;
  logic        fwd_a_valid_o;
  logic [31:0] fwd_a_data_o;
  logic        fwd_b_valid_o;
  logic [31:0] fwd_b_data_o;

  regfile_writeback #(.STARVE_LIMIT(Limit)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .lsu_ready_o(lsu_ready_o),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_we_o(rd_we_o),
    .rs_addr_a_i(rs_addr_a_i), .rs_addr_b_i(rs_addr_b_i),
    .rs_a_busy_o(rs_a_busy_o), .rs_b_busy_o(rs_b_busy_o),
    .fwd_a_valid_o(fwd_a_valid_o), .fwd_a_data_o(fwd_a_data_o),
    .fwd_b_valid_o(fwd_b_valid_o), .fwd_b_data_o(fwd_b_data_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int errs = 0;

  // Reference model state: what the block should remember, in plain terms.
  bit          m_known = 0;
  bit          m_busy[32];
  bit          m_full;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_wait;  // cycles the buffered load has been passed over

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rst_i = 0; issue_valid_i = 0; issue_rd_i = 0;
    alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
    lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
    rs_addr_a_i = 0; rs_addr_b_i = 0;
  endtask

  // Inputs are already applied (posedge+1). Check combinational outputs
  // against the model, clock once, then advance the model.
  task automatic cycle();
    int src;  // 0 none, 1 ALU, 2 buffer
    logic [4:0] e_addr;
    logic [31:0] e_data;
    bit e_we, e_fa, e_fb;
    #2;
    if (m_full && m_wait == Limit) src = 2;
    else if (alu_valid_i)          src = 1;
    else if (m_full)               src = 2;
    else                           src = 0;
    e_addr = (src == 1) ? alu_rd_i : (src == 2) ? m_rd : 5'd0;
    e_data = (src == 1) ? alu_data_i : (src == 2) ? m_data : 32'd0;
    e_we = (src != 0) && (e_addr != 0);
    e_fa = e_we && (e_addr == rs_addr_a_i) && (rs_addr_a_i != 0);
    e_fb = e_we && (e_addr == rs_addr_b_i) && (rs_addr_b_i != 0);
    if (m_known) begin
      chk("alu_ready", 32'(alu_ready_o), 32'(!(m_full && m_wait == Limit)));
      chk("lsu_ready", 32'(lsu_ready_o), 32'(!m_full));
      chk("rd_we", 32'(rd_we_o), 32'(e_we));
      chk("rd_addr", 32'(rd_addr_o), 32'(e_addr));
      chk("rd_data", rd_data_o, e_data);
      chk("fwd_a_valid", 32'(fwd_a_valid_o), 32'(e_fa));
      chk("fwd_b_valid", 32'(fwd_b_valid_o), 32'(e_fb));
      chk("fwd_a_data", fwd_a_data_o, e_fa ? e_data : 32'd0);
      chk("fwd_b_data", fwd_b_data_o, e_fb ? e_data : 32'd0);
      chk("rs_a_busy", 32'(rs_a_busy_o), 32'(m_busy[rs_addr_a_i] && !e_fa));
      chk("rs_b_busy", 32'(rs_b_busy_o), 32'(m_busy[rs_addr_b_i] && !e_fb));
    end
    @(posedge clk_i);
    if (rst_i) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_full = 0; m_wait = 0; m_known = 1;
    end else begin
      if (e_we) m_busy[e_addr] = 0;
      if (issue_valid_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1;
      if (m_full && src != 2) m_wait = (m_wait < Limit) ? m_wait + 1 : Limit;
      else m_wait = 0;
      if (src == 2) m_full = 0;
      else if (lsu_valid_i && !m_full) begin
        m_full = 1; m_rd = lsu_rd_i; m_data = lsu_data_i;
      end
    end
    #1;
  endtask

  initial begin
    idle_inputs();
    @(posedge clk_i); #1;
    rst_i = 1;
    cycle();
    idle_inputs();
    #1;
    // Post-reset values
    chk("post_rst lsu_ready", 32'(lsu_ready_o), 32'd1);
    chk("post_rst alu_ready", 32'(alu_ready_o), 32'd1);
    chk("post_rst rd_we", 32'(rd_we_o), 32'd0);
    cycle();

    // Issue x5, ALU writes it two cycles later with forwarding
    issue_valid_i = 1; issue_rd_i = 5; cycle();
    idle_inputs(); rs_addr_a_i = 5; #1;
    chk("x5 pending", 32'(rs_a_busy_o), 32'd1);
    cycle();
    alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'hDEADBEEF; rs_addr_a_i = 5; #1;
    chk("x5 we", 32'(rd_we_o), 32'd1);
    chk("x5 addr", 32'(rd_addr_o), 32'd5);
    chk("x5 data", rd_data_o, 32'hDEADBEEF);
    chk("x5 fwd", 32'(fwd_a_valid_o), 32'd1);
    chk("x5 busy_fwd", 32'(rs_a_busy_o), 32'd0);
    cycle();
    idle_inputs(); rs_addr_a_i = 5; #1;
    chk("x5 cleared", 32'(rs_a_busy_o), 32'd0);
    cycle();

    // Starvation: load x7 blocked by a continuously valid ALU
    alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'h33;
    lsu_valid_i = 1; lsu_rd_i = 7; lsu_data_i = 32'h11;
    cycle();
    lsu_valid_i = 0;
    for (int k = 0; k < Limit; k++) begin
      #1;
      chk("starve blocked addr", 32'(rd_addr_o), 32'd3);
      cycle();
    end
    #1;
    chk("starve win addr", 32'(rd_addr_o), 32'd7);
    chk("starve win data", rd_data_o, 32'h11);
    chk("starve win alu_ready", 32'(alu_ready_o), 32'd0);
    cycle();
    #1;
    chk("after starve alu_ready", 32'(alu_ready_o), 32'd1);
    chk("after starve lsu_ready", 32'(lsu_ready_o), 32'd1);
    cycle();

    // ALU result to x0
    idle_inputs(); alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 32'h55; #1;
    chk("x0 alu_ready", 32'(alu_ready_o), 32'd1);
    chk("x0 we", 32'(rd_we_o), 32'd0);
    chk("x0 fwd_a", 32'(fwd_a_valid_o), 32'd0);
    cycle();

    // Same-cycle issue and writeback of x9: set wins
    idle_inputs(); issue_valid_i = 1; issue_rd_i = 9;
    alu_valid_i = 1; alu_rd_i = 9; alu_data_i = 32'h99; #1;
    chk("x9 we", 32'(rd_we_o), 32'd1);
    cycle();
    idle_inputs(); rs_addr_b_i = 9; #1;
    chk("x9 still busy", 32'(rs_b_busy_o), 32'd1);
    cycle();

    // Reset with buffered load to x4 and busy x4
    issue_valid_i = 1; issue_rd_i = 4; lsu_valid_i = 1; lsu_rd_i = 4; lsu_data_i = 32'h44;
    alu_valid_i = 1; alu_rd_i = 1; alu_data_i = 32'h1;
    cycle();
    idle_inputs(); rst_i = 1; alu_valid_i = 1; alu_rd_i = 1;
    cycle();
    idle_inputs(); rs_addr_a_i = 4; #1;
    chk("rst drop we", 32'(rd_we_o), 32'd0);
    chk("rst x4 busy", 32'(rs_a_busy_o), 32'd0);
    chk("rst lsu_ready", 32'(lsu_ready_o), 32'd1);
    cycle();

    // Held lsu_valid while buffer full
    alu_valid_i = 1; alu_rd_i = 2; alu_data_i = 32'h2;
    lsu_valid_i = 1; lsu_rd_i = 12; lsu_data_i = 32'hA5;
    cycle();
    lsu_rd_i = 13; lsu_data_i = 32'hB6;
    #1; chk("held not ready", 32'(lsu_ready_o), 32'd0);
    cycle();
    alu_valid_i = 0; #1;
    chk("drain addr", 32'(rd_addr_o), 32'd12);
    chk("drain data", rd_data_o, 32'hA5);
    cycle();
    #1; chk("reaccept ready", 32'(lsu_ready_o), 32'd1);
    cycle();
    lsu_valid_i = 0; #1;
    chk("second load addr", 32'(rd_addr_o), 32'd13);
    cycle();
    idle_inputs(); #1;
    chk("no duplicate", 32'(rd_we_o), 32'd0);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_i         = ($urandom_range(0, 79) == 0);
      issue_valid_i = $urandom_range(0, 1);
      issue_rd_i    = 5'($urandom_range(0, 15));
      alu_valid_i   = ($urandom_range(0, 9) < 7);
      alu_rd_i      = 5'($urandom_range(0, 15));
      alu_data_i    = $urandom;
      lsu_valid_i   = $urandom_range(0, 1);
      lsu_rd_i      = 5'($urandom_range(0, 15));
      lsu_data_i    = $urandom;
      rs_addr_a_i   = 5'($urandom_range(0, 15));
      rs_addr_b_i   = 5'($urandom_range(0, 15));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive cycles a buffered LSU result may be blocked by the ALU before it takes priority (legal range 1..15).
REQ-002 SHALL have one clock and a synchronous, active-high reset. Ports: clk_i  in  1  clock, all state on rising edge; rst_i  in  1  synchronous active-high reset.
REQ-003 SHALL have issue_valid_i  in  1  an instruction writing issue_rd_i is issued this cycle.
REQ-004 SHALL have issue_rd_i  in  5  destination register of the issued instruction.
REQ-005 SHALL have alu_valid_i  in  1, alu_rd_i  in  5, alu_data_i  in  32, meaning the ALU result is offered.
REQ-006 SHALL have alu_ready_o  out  1  ALU result accepted this cycle.
REQ-007 SHALL have lsu_valid_i  in  1, lsu_rd_i  in  5, lsu_data_i  in  32, meaning the load result is offered.
REQ-008 SHALL have lsu_ready_o  out  1  load result accepted into the holding buffer this cycle.
REQ-009 SHALL have rd_addr_o  out  5, rd_data_o  out  32, rd_we_o  out  1, which drive the register file write port.
REQ-010 SHALL have rs_addr_a_i  in  5 and rs_addr_b_i  in  5, the operand addresses being read.
REQ-011 SHALL have rs_a_busy_o  out  1 and rs_b_busy_o  out  1, set when the operand is pending and cannot be forwarded.
REQ-012 SHALL have fwd_a_valid_o  out  1, fwd_a_data_o  out  32, fwd_b_valid_o  out  1 and fwd_b_data_o  out  32, which carry the same-cycle writeback forward.

Function
REQ-013 SHALL hold a 1-entry LSU buffer (rd, data, full flag), a busy scoreboard busy[31:1] with busy[0] fixed at 0, and a 4-bit starve counter.
REQ-014 SHALL drive lsu_ready_o = !buf_full; a handshake (lsu_valid_i && lsu_ready_o) loads the buffer at the edge.
REQ-015 SHALL select the writeback source each cycle as follows:
- buffer, if full and starve counter == STARVE_LIMIT;
- else ALU, if alu_valid_i;
- else buffer, if full;
- else none.
REQ-016 SHALL drive alu_ready_o = 1 unless the buffer is selected while full and starved.
REQ-017 SHALL make the write port combinational from the selected source: rd_addr_o/rd_data_o follow it, and rd_we_o = source selected && rd != 0.
REQ-018 SHALL drive rd_addr_o = 0, rd_data_o = 0 and rd_we_o = 0 when no source is selected.
REQ-019 SHALL consume a result addressed to x0 (handshake completes) with no write and no scoreboard change.
REQ-020 SHALL clear the buffer full flag at the edge when the buffer is selected; a new LSU handshake cannot happen in that same cycle, since lsu_ready_o was 0.
REQ-021 SHALL update the starve counter as follows:
- increments (saturating at STARVE_LIMIT) each cycle the buffer is full and not selected;
- resets to 0 when the buffer is selected or empty.
REQ-022 SHALL handle the scoreboard as follows:
- at the edge, busy[issue_rd_i] is set when issue_valid_i && issue_rd_i != 0;
- busy[rd_addr_o] is cleared when rd_we_o;
- if both hit the same register in one cycle, set wins.
REQ-023 SHALL forward: fwd_x_valid_o = rd_we_o && rd_addr_o == rs_addr_x_i && rs_addr_x_i != 0, and fwd_x_data_o = rd_data_o, else 0.
REQ-024 SHALL compute rs_x_busy_o = busy[rs_addr_x_i] && !fwd_x_valid_o; the result is always 0 for address 0.
REQ-025 SHALL accept at most one ALU and one LSU handshake per cycle and write at most one register per cycle; no result SHALL be dropped or duplicated.
REQ-026 SHALL have no internal check for two outstanding writers to the same rd; preventing that is the issue stage's responsibility.

Reset
REQ-027 SHALL, while rst_i is high at an edge, clear busy[31:1], the buffer full flag and the starve counter.
REQ-028 SHALL have these values in the cycle after reset: lsu_ready_o = 1, alu_ready_o = 1, rd_we_o = 0 (absent alu_valid_i), all busy/fwd outputs 0.
REQ-029 SHALL discard a buffered result present at reset without writing it.

Verification
REQ-030 SHALL pass this scenario: issue rd=5, then 2 cycles later alu_valid_i rd=5 data=0xDEADBEEF -> rd_we_o=1, addr 5, data 0xDEADBEEF; with rs_addr_a_i=5 in that cycle, fwd_a_valid_o=1 and rs_a_busy_o=0; busy[5]=0 the next cycle.
REQ-031 SHALL pass this scenario: LSU rd=7 data=0x11 accepted while the ALU is continuously valid (rd=3) -> the buffer waits exactly STARVE_LIMIT=4 cycles; in the 5th cycle rd_addr_o=7, rd_data_o=0x11 and alu_ready_o=0; the next cycle alu_ready_o=1 and lsu_ready_o=1.
REQ-032 SHALL pass this scenario: ALU result with rd=0, data=0x55 -> alu_ready_o=1, rd_we_o=0, fwd outputs 0, all busy unchanged.
REQ-033 SHALL pass this scenario: in one cycle, issue rd=9 and ALU writeback rd=9 -> the write occurs and busy[9]=1 afterwards.
REQ-034 SHALL pass this scenario: buffer full (rd=4) and busy[4]=1, then rst_i for 1 cycle -> no write to 4, busy[4]=0, lsu_ready_o=1.
REQ-035 SHALL pass this scenario: lsu_valid_i held with the buffer full -> lsu_ready_o=0 until the buffer drains, then exactly one new acceptance; the original data is written once.
